// File: rtl/ttl_tdm_demux.sv
// Dual-lane time-division demultiplexer: counts slots and steers each serial bit into its
// slot position, presenting the reassembled word per lane with a one-cycle valid pulse.
module ttl_tdm_demux #(
    parameter int SLOTS = 4,
    parameter int SEL_W = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sync,
    input  logic             enable1,
    input  logic             enable2,
    input  logic             d1,
    input  logic             d2,
    output logic [SLOTS-1:0] c1,
    output logic [SLOTS-1:0] c2,
    output logic             y_valid,
    output logic [SEL_W-1:0] select,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [0:0] {StHunt, StLock} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] slot_q;
    logic [SLOTS-1:0] shadow1_q, shadow2_q;
    logic [SLOTS-1:0] word1, word2;
    logic             b1, b2, last;

    // Shadow word with the current slot's bit merged in, so completion includes the last bit.
    always_comb begin
        b1           = d1 & ~enable1;
        b2           = d2 & ~enable2;
        word1        = shadow1_q;
        word2        = shadow2_q;
        word1[slot_q] = b1;
        word2[slot_q] = b2;
        last         = (slot_q == SEL_W'(SLOTS - 1));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StHunt;
            slot_q    <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
            c1        <= '0;
            c2        <= '0;
            y_valid   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            y_valid  <= 1'b0;
            sync_err <= 1'b0;
            case (state_q)
                StHunt: begin
                    if (sync) begin
                        shadow1_q <= {{(SLOTS - 1){1'b0}}, b1};
                        shadow2_q <= {{(SLOTS - 1){1'b0}}, b2};
                        slot_q    <= SEL_W'(1);
                        state_q   <= StLock;
                    end
                end
                StLock: begin
                    if (sync && slot_q != '0) begin
                        // Misplaced sync: drop the partial frame and restart at slot 0.
                        shadow1_q <= {{(SLOTS - 1){1'b0}}, b1};
                        shadow2_q <= {{(SLOTS - 1){1'b0}}, b2};
                        slot_q    <= SEL_W'(1);
                        sync_err  <= 1'b1;
                    end else begin
                        shadow1_q <= word1;
                        shadow2_q <= word2;
                        slot_q    <= slot_q + SEL_W'(1);
                        if (last) begin
                            c1      <= word1;
                            c2      <= word2;
                            y_valid <= 1'b1;
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

    assign select = slot_q;
    assign locked = (state_q == StLock);

endmodule
